msrr_ctrl: RTL and testbench

MSRR_CTRL -- requirements
Module: msrr_ctrl

---
 rtl/msrr_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_msrr_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/msrr_ctrl.sv
//-----------------------------------------------------------------------------
// msrr_ctrl -- sequencer for an external 8-bit universal shift register.
//
// Accepts a parallel word over a valid/ready handshake, parallel-loads it into
// the shift register, then shifts it out one bit per accepted serial beat
// (LSB-first or MSB-first). The word ends with a one-cycle done pulse and
// GAP idle cycles.
//
// Optional feature macro: MSRR_CTRL_PARITY_EN
//   When defined, an even-parity bit (XOR of the word) is sent after bit 7.
//   When undefined, the parity state and parity logic are not built.
//
// Parameters:
//   FILL      - serial fill bit driven on sln
//   GAP       - idle cycles after DONE before returning to IDLE (0..7)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   in_data   - parallel word to transmit
//   in_dir    - 0 = LSB-first (shift right), 1 = MSB-first (shift left)
//   in_valid  - word offered
//   in_ready  - controller can accept a word (IDLE only)
//   po        - parallel output of the shift register being sequenced
//   mode      - shift register command: 00 hold, 01 right, 10 left, 11 load
//   pi        - parallel load data (latched word)
//   sln       - serial fill bit to the shift register
//   ser_out   - current serial bit
//   ser_valid - ser_out valid this cycle
//   ser_ready - downstream accepts ser_out
//   done      - one-cycle pulse at end of each word
//-----------------------------------------------------------------------------
module msrr_ctrl #(
  parameter logic FILL = 1'b0,
  parameter int   GAP  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_dir,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] po,
  output logic [1:0] mode,
  output logic [7:0] pi,
  output logic       sln,
  output logic       ser_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
`ifdef MSRR_CTRL_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_GAPW   = 3'd5
  } state_t;

  // Last gap-counter value before leaving GAPW; unused when GAP is zero.
  localparam int         GAP_LAST_I = (GAP > 0) ? (GAP - 1) : 0;
  localparam logic [2:0] GAP_LAST   = GAP_LAST_I[2:0];
  localparam logic       HAS_GAP    = (GAP > 0);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

`ifdef MSRR_CTRL_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] w);
    return ^w;
  endfunction
`endif

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_nxt_s;
  logic [2:0] gap_cnt_r;
  logic [2:0] gap_cnt_nxt_s;
  logic [7:0] word_r;
  logic       dir_r;
  logic       accept_s;

  // State-decoded output registers, updated from the next state so they are
  // aligned with state_r.
  logic       idle_r;
  logic       load_r;
  logic       shift_r;
  logic       ser_valid_r;
  logic       done_r;
`ifdef MSRR_CTRL_PARITY_EN
  logic       parity_st_r;
  logic       par_r;
`endif

  logic [1:0] mode_s;
  logic       ser_out_s;

  // Handshake qualifier: a word is taken only while idle.
  always_comb begin
    accept_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = in_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s   = ST_SHIFT;
        bit_cnt_nxt_s = 3'd0;
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          // Counter wraps 7 -> 0 naturally on the final bit.
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef MSRR_CTRL_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_DONE;
`endif
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s   = ST_SHIFT;
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
`ifdef MSRR_CTRL_PARITY_EN
      ST_PARITY: begin
        if (ser_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_DONE: begin
        gap_cnt_nxt_s = 3'd0;
        if (HAS_GAP) begin
          state_nxt_s = ST_GAPW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GAPW: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s   = ST_IDLE;
          gap_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = ST_GAPW;
          gap_cnt_nxt_s = gap_cnt_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = 3'd0;
        gap_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // FSM state, counters, latched word and registered output decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      gap_cnt_r   <= 3'd0;
      word_r      <= 8'h00;
      dir_r       <= 1'b0;
      idle_r      <= 1'b1;
      load_r      <= 1'b0;
      shift_r     <= 1'b0;
      ser_valid_r <= 1'b0;
      done_r      <= 1'b0;
`ifdef MSRR_CTRL_PARITY_EN
      parity_st_r <= 1'b0;
      par_r       <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      if (accept_s) begin
        word_r <= in_data;
        dir_r  <= in_dir;
`ifdef MSRR_CTRL_PARITY_EN
        par_r  <= even_parity(in_data);
`endif
      end else begin
        word_r <= word_r;
        dir_r  <= dir_r;
      end
      idle_r      <= (state_nxt_s == ST_IDLE);
      load_r      <= (state_nxt_s == ST_LOAD);
      shift_r     <= (state_nxt_s == ST_SHIFT);
      done_r      <= (state_nxt_s == ST_DONE);
`ifdef MSRR_CTRL_PARITY_EN
      parity_st_r <= (state_nxt_s == ST_PARITY);
      ser_valid_r <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_PARITY);
`else
      ser_valid_r <= (state_nxt_s == ST_SHIFT);
`endif
    end
  end

  // Shift register command. The shift direction is only issued on an
  // accepted serial beat so a stalled bit stays on ser_out.
  always_comb begin
    mode_s = MODE_HOLD;
    if (load_r) begin
      mode_s = MODE_LOAD;
    end else if (shift_r && ser_ready) begin
      if (dir_r) begin
        mode_s = MODE_LEFT;
      end else begin
        mode_s = MODE_RIGHT;
      end
    end else begin
      mode_s = MODE_HOLD;
    end
  end

  // Serial bit: the outgoing end of the shift register, or the parity bit.
  always_comb begin
    ser_out_s = 1'b0;
    if (shift_r) begin
      if (dir_r) begin
        ser_out_s = po[7];
      end else begin
        ser_out_s = po[0];
      end
`ifdef MSRR_CTRL_PARITY_EN
    end else if (parity_st_r) begin
      ser_out_s = par_r;
`endif
    end else begin
      ser_out_s = 1'b0;
    end
  end

  // in_ready is gated by rst so it reads 0 while reset is held and rises in
  // the very first idle cycle after release.
  assign in_ready  = idle_r & rst;
  assign mode      = mode_s;
  assign pi        = word_r;
  assign sln       = FILL;
  assign ser_out   = ser_out_s;
  assign ser_valid = ser_valid_r;
  assign done      = done_r;

endmodule

// File: tb/tb_msrr_ctrl.sv
//-----------------------------------------------------------------------------
// tb_msrr_ctrl -- directed self-checking bench for msrr_ctrl (FILL=0, GAP=2).
// A behavioural universal shift register is driven by mode/pi/sln and feeds
// po back to the controller. Expected serial sequences are hand-written.
//-----------------------------------------------------------------------------
module tb_msrr_ctrl;

  localparam int GAP_P = 2;
`ifdef MSRR_CTRL_PARITY_EN
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_dir = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] po;
  logic [1:0] mode;
  logic [7:0] pi;
  logic       sln;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready = 1'b1;
  logic       done;

  logic [7:0] sr = 8'h00;
  int         cyc_cnt = 0;
  int         last_acc = 0;
  int         test_cnt = 0;
  int         fail_cnt = 0;

  msrr_ctrl #(.FILL(1'b0), .GAP(GAP_P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .po        (po),
    .mode      (mode),
    .pi        (pi),
    .sln       (sln),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency and period measurements.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural universal shift register.
  always @(posedge clk) begin
    case (mode)
      2'b01:   sr <= {sln, sr[7:1]};
      2'b10:   sr <= {sr[6:0], sln};
      2'b11:   sr <= pi;
      default: sr <= sr;
    endcase
  end
  assign po = sr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete word. seq[i] is the i-th bit expected on ser_out; a set bit
  // in stall holds ser_ready low for 3 cycles before bit i is accepted.
  // exp_lat is the acceptance-to-done distance without parity.
  task automatic run_word(input logic [7:0] data, input logic dir, input logic [7:0] seq,
                          input logic [7:0] stall, input logic exp_par, input int exp_lat,
                          input bit chk_period);
    int acc;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_dir = dir; ser_ready = 1'b1;
    #1;
    check_eq("idle_in_ready", in_ready, 1'b1);
    check_eq("idle_mode", mode, 2'b00);
    if (chk_period) check_eq("acc_period", cyc_cnt - last_acc, 11 + GAP_P + PAR_EXTRA);
    acc = cyc_cnt;
    last_acc = cyc_cnt;
    // Junk on the input side after acceptance must be ignored.
    @(negedge clk);
    in_valid = 1'b0; in_data = ~data; in_dir = ~dir;
    #1;
    check_eq("load_mode", mode, 2'b11);
    check_eq("load_pi", pi, data);
    check_eq("load_in_ready", in_ready, 1'b0);
    check_eq("load_ser_valid", ser_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (stall[i]) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          ser_ready = 1'b0;
          #1;
          check_eq("stall_mode", mode, 2'b00);
          check_eq("stall_valid", ser_valid, 1'b1);
          check_eq("stall_bit", ser_out, seq[i]);
        end
      end
      @(negedge clk);
      ser_ready = 1'b1;
      #1;
      check_eq("shift_valid", ser_valid, 1'b1);
      check_eq("shift_bit", ser_out, seq[i]);
      check_eq("shift_mode", mode, dir ? 2'b10 : 2'b01);
      check_eq("shift_in_ready", in_ready, 1'b0);
      check_eq("shift_done", done, 1'b0);
      check_eq("shift_sln", sln, 1'b0);
    end
`ifdef MSRR_CTRL_PARITY_EN
    @(negedge clk);
    #1;
    check_eq("par_valid", ser_valid, 1'b1);
    check_eq("par_bit", ser_out, exp_par);
    check_eq("par_mode", mode, 2'b00);
`else
    if (exp_par !== 1'bx) begin end
`endif
    @(negedge clk);
    #1;
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_mode", mode, 2'b00);
    check_eq("done_valid", ser_valid, 1'b0);
    check_eq("done_ser_out", ser_out, 1'b0);
    check_eq("done_po", po, 8'h00);
    check_eq("done_latency", cyc_cnt - acc, exp_lat + PAR_EXTRA);
    for (int g = 0; g < GAP_P; g++) begin
      @(negedge clk);
      #1;
      check_eq("gap_done", done, 1'b0);
      check_eq("gap_in_ready", in_ready, 1'b0);
      check_eq("gap_mode", mode, 2'b00);
      check_eq("gap_valid", ser_valid, 1'b0);
    end
  endtask

  initial begin
    // Reset state while rst is held low.
    #12;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_mode", mode, 2'b00);
    check_eq("rst_pi", pi, 8'h00);
    check_eq("rst_ser_valid", ser_valid, 1'b0);
    check_eq("rst_ser_out", ser_out, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sln", sln, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1'b1);

    // A5 LSB-first: 1,0,1,0,0,1,0,1.
    run_word(8'hA5, 1'b0, 8'b1010_0101, 8'h00, 1'b0, 10, 1'b0);
    // 81 MSB-first: 1,0,0,0,0,0,0,1.
    run_word(8'h81, 1'b1, 8'b1000_0001, 8'h00, 1'b0, 10, 1'b0);
    // 3C LSB-first with stalls before bits 2 and 5: done 6 cycles later.
    run_word(8'h3C, 1'b0, 8'b0011_1100, 8'b0010_0100, 1'b0, 16, 1'b0);

    // Reset in the 4th SHIFT cycle of FF aborts the word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_mode", mode, 2'b00);
    check_eq("abort_pi", pi, 8'h00);
    check_eq("abort_in_ready", in_ready, 1'b0);
    check_eq("abort_valid", ser_valid, 1'b0);
    check_eq("abort_ser_out", ser_out, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("abort_no_done", done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_rel_ready", in_ready, 1'b1);
    check_eq("abort_rel_done", done, 1'b0);

    // 0F MSB-first after the abort: 0,0,0,0,1,1,1,1.
    run_word(8'h0F, 1'b1, 8'b1111_0000, 8'h00, 1'b0, 10, 1'b0);
    // 07 then 03 back-to-back: parity bits 1 then 0, minimum word period.
    run_word(8'h07, 1'b0, 8'b0000_0111, 8'h00, 1'b1, 10, 1'b0);
    run_word(8'h03, 1'b0, 8'b0000_0011, 8'h00, 1'b0, 10, 1'b1);

    @(negedge clk);
    #1;
    check_eq("end_in_ready", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
